// File: rtl/bcd2binary.sv
// rtl/bcd2binary.sv - multi-cycle packed-BCD to binary converter (reverse double dabble)
module bcd2binary #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int SR_W  = 4*DIGITS + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t             state_q;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [BIN_W-1:0]   bin_q;
   logic               busy_q, done_q, err_q;
   logic               bad_digit;
   logic               last_iter;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // One reverse double-dabble step: shift right, then correct digits that borrowed a 10 into bit 3.
   always_comb begin
      sr_d = sr_q >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_d[BIN_W + 4*i +: 4] >= 4'd8)
            sr_d[BIN_W + 4*i +: 4] = sr_d[BIN_W + 4*i +: 4] - 4'd3;
      end
   end

   assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (bad_digit) begin
                     err_q   <= 1'b1;
                     bin_q   <= '0;
                     state_q <= DONE;
                  end else begin
                     sr_q    <= {bcd, {BIN_W{1'b0}}};
                     cnt_q   <= '0;
                     err_q   <= 1'b0;
                     state_q <= CONV;
                  end
               end
            end
            CONV: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + 1'b1;
               if (last_iter) begin
                  bin_q   <= sr_d[BIN_W-1:0];
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bin  = bin_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd2binary.sv
// tb/tb_bcd2binary.sv - table, random and corner-sequence checks for bcd2binary
module tb_bcd2binary;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [4*DIGITS-1:0]  bcd = '0;
   logic [BIN_W-1:0]     bin;
   logic                 busy, done, err;

   int tests = 0;
   int fails = 0;

   bcd2binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
      .bin(bin), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] b;
      int          exp_bin;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void ref_model(input logic [11:0] b, output int v, output bit e);
      int d;
      v = 0;
      e = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) e = 1'b1;
         v = v * 10 + d;
      end
      if (e) v = 0;
   endfunction

   function automatic logic [11:0] to_bcd(input int k);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(k % 10);
         k = k / 10;
      end
      return r;
   endfunction

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 40);
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic run_conv(input string name, input logic [11:0] b, input int exp_bin,
                           input bit exp_err, input int exp_lat);
      int n;
      bcd   = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, "_busy"}, int'(busy), 1);
      bcd = 12'($urandom);
      wait_done(n);
      chk({name, "_lat"}, n, exp_lat);
      chk({name, "_bin"}, int'(bin), exp_bin);
      chk({name, "_err"}, int'(err), int'(exp_err));
      tick();
      chk({name, "_pulse"}, int'(done), 0);
      tick();
      chk({name, "_hold"}, int'(bin), exp_bin);
   endtask

   initial begin
      vec_t vecs[$];
      int   v, n, cnt, seen_bin;
      bit   e;
      logic [11:0] rb;

      vecs.push_back('{12'h999, 999, 1'b0, 11});
      vecs.push_back('{12'h000,   0, 1'b0, 11});
      vecs.push_back('{12'h255, 255, 1'b0, 11});
      vecs.push_back('{12'h1A3,   0, 1'b1,  1});
      vecs.push_back('{12'h042,  42, 1'b0, 11});
      vecs.push_back('{12'hF00,   0, 1'b1,  1});
      vecs.push_back('{12'h00C,   0, 1'b1,  1});
      vecs.push_back('{12'h009,   9, 1'b0, 11});
      vecs.push_back('{12'h090,  90, 1'b0, 11});
      vecs.push_back('{12'h500, 500, 1'b0, 11});

      #12;
      chk("rst_bin",  int'(bin),  0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err",  int'(err),  0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_conv($sformatf("vec%0d", i), vecs[i].b, vecs[i].exp_bin,
                                 vecs[i].exp_err, vecs[i].exp_lat);

      for (int i = 0; i < 60; i++) begin
         rb = 12'($urandom);
         ref_model(rb, v, e);
         run_conv($sformatf("rnd_%03h", rb), rb, v, e, e ? 1 : 11);
      end

      // A second start four cycles into a conversion must be ignored.
      bcd = 12'h128; start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      bcd = 12'h777; start = 1'b1; tick(); start = 1'b0;
      cnt = 0; seen_bin = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done) begin cnt++; seen_bin = int'(bin); end
      end
      chk("ignore_done_cnt", cnt, 1);
      chk("ignore_bin", seen_bin, 128);

      // Asynchronous reset five cycles into a conversion aborts it.
      bcd = 12'h321; start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("abort_bin",  int'(bin),  0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      tick();
      #2 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) cnt++;
      end
      chk("abort_no_done", cnt, 0);
      run_conv("after_rst", 12'h500, 500, 1'b0, 11);

      // Sweep every valid operand with start held high; each result 12 cycles apart.
      bcd = to_bcd(0); start = 1'b1; tick();
      for (int k = 0; k < 1000; k++) begin
         bcd = to_bcd((k + 1) % 1000);
         wait_done(n);
         tests++;
         if (n !== 11 || int'(bin) !== k || err !== 1'b0) begin
            fails++;
            $display("FAIL sweep_%0d: got bin %0d err %0d lat %0d expected bin %0d err 0 lat 11",
                     k, bin, err, n, k);
         end
         tick();
      end
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bcd2binary.md
BCD2BINARY -- requirements
Module: bcd2binary

Interface
REQ-001 Parameter DIGITS, default 3: number of packed BCD digits at the input.
REQ-002 Parameter BIN_W, default 10: binary result width; SHALL satisfy 2^BIN_W > 10^DIGITS - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request conversion of bcd; sampled on rising clk edge.
REQ-006 bcd  input  4*DIGITS  packed BCD operand; digit 0 in bits [3:0].
REQ-007 bin  output  BIN_W  binary result, registered.
REQ-008 busy  output  1  high while a request is in progress (states CONV and DONE).
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  high when the last accepted request had an invalid digit.

Function
REQ-011 FSM states SHALL be IDLE, CONV and DONE, one-hot or encoded, registered.
REQ-012 IDLE: start=1 at an edge accepts the request; otherwise remain IDLE.
REQ-013 On accept with all digits <= 9: load a DIGITS*4+BIN_W shift register as {bcd, zeros}, clear the iteration counter, clear err, go to CONV.
REQ-014 On accept with any digit > 9: set err=1, set bin=0, go directly to DONE; no shifts performed.
REQ-015 CONV, each cycle: shift the whole register right 1 bit, then subtract 3 from every BCD digit field whose shifted value is >= 8; increment the counter.
REQ-016 CONV SHALL perform exactly BIN_W iterations; on the BIN_W-th iteration, the low BIN_W bits are written to bin and the state goes to DONE.
REQ-017 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-018 Latency, valid input: done is high in the cycle following the (BIN_W+1)-th rising edge after the accepting edge (11 edges for the defaults).
REQ-019 Latency, invalid input: done is high in the cycle following the first edge after the accepting edge.
REQ-020 start while busy=1, including during DONE, SHALL be ignored, with no effect on state, bin or err.
REQ-021 start must be re-sampled in IDLE; a start held high across DONE is accepted at the first edge in IDLE.
REQ-022 bcd SHALL be captured only at the accepting edge; later changes during CONV have no effect.
REQ-023 bin and err SHALL hold their values from the DONE cycle until the next accepted request updates them.
REQ-024 The counter SHALL be ceil(log2(BIN_W+1)) bits wide and SHALL not wrap within a conversion.
REQ-025 Result SHALL equal the decimal value of bcd exactly for every valid operand from 0 to 10^DIGITS - 1.

Reset
REQ-026 rst_n=0 asynchronously forces: state IDLE, bin=0, busy=0, done=0, err=0, counter=0, shift register=0.
REQ-027 Reset asserted mid-conversion SHALL abort with no done pulse; the first request after rst_n deasserts proceeds normally.
REQ-028 The first edge after rst_n deasserts may accept start.

Verification
REQ-029 bcd=12'h999, start pulse -> done 11 edges later, bin=10'd999 (10'h3E7), err=0.
REQ-030 bcd=12'h000, and separately 12'h255 -> bin=0, then bin=255; err=0; each at 11-edge latency.
REQ-031 bcd=12'h1A3 -> done after 1 edge, err=1, bin=0; a following bcd=12'h042 -> err=0, bin=42.
REQ-032 start pulsed again 4 cycles into a 12'h128 conversion with bcd=12'h777 -> single done, bin=128; second request not executed.
REQ-033 rst_n pulsed low 5 cycles into a conversion -> outputs 0 immediately, no done; next request 12'h500 -> bin=500.
REQ-034 Exhaustive sweep of all 1000 valid operands with a start held high continuously -> every result matches, with back-to-back spacing of 12 cycles.
